// File: rtl/pc_ctrl_pkg.sv
// Shared next-PC select codes and reset defaults
// for the fetch-side PC controller.
package pc_ctrl_pkg;

   localparam logic [2:0] NPC_SEQ = 3'd0;
   localparam logic [2:0] NPC_BR  = 3'd1;
   localparam logic [2:0] NPC_J   = 3'd2;
   localparam logic [2:0] NPC_JR  = 3'd3;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
   localparam logic [31:0] IM_BASE_DEF  = 32'h0000_3000;

   // Word offset of a branch, sign-extended and scaled to bytes.
   function automatic logic [31:0] br_off(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/pc_ctrl_npc_calc.sv
// Combinational next-PC mux: picks the fetch target
// and flags taken D-stage control transfers.
module pc_ctrl_npc_calc
   import pc_ctrl_pkg::*;
(
   input  logic [31:0] pc_f,
   input  logic [31:0] pc_d,
   input  logic        valid_d,
   input  logic [2:0]  npc_op,
   input  logic        br_cond,
   input  logic [15:0] imm16,
   input  logic [25:0] imm26,
   input  logic [31:0] rs,
   output logic [31:0] target,
   output logic        redirect
);

   logic [31:0] seq_pc;

   assign seq_pc = pc_f + 32'd4;

   // Target select; an empty D stage always falls through.
   always_comb begin
      target   = seq_pc;
      redirect = 1'b0;
      if (valid_d) begin
         case (npc_op)
            NPC_BR: begin
               if (br_cond) begin
                  target   = pc_d + 32'd4 + br_off(imm16);
                  redirect = 1'b1;
               end
            end
            NPC_J: begin
               target   = {pc_d[31:28], imm26, 2'b00};
               redirect = 1'b1;
            end
            NPC_JR: begin
               target   = rs;
               redirect = 1'b1;
            end
            default: begin
               target   = seq_pc;
               redirect = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/pc_ctrl.sv
// Fetch-side PC owner: F PC, F->D latch, taken-redirect
// counter and fetch address range check.
module pc_ctrl
   import pc_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
   parameter int unsigned IM_WORDS = 4096
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        stall_i,
   input  logic [2:0]  npc_op_d,
   input  logic        br_cond_d,
   input  logic [15:0] imm16_d,
   input  logic [25:0] imm26_d,
   input  logic [31:0] rs_d,
   output logic [31:0] pc_f,
   output logic [31:0] pc_d,
   output logic        valid_d,
   output logic [31:0] link_d,
   output logic        redirect_d,
   output logic        adel_f,
   output logic [31:0] taken_cnt
);

   // Upper bound held in 33 bits so a range touching 2^32 still works.
   localparam logic [32:0] IM_END =
      {1'b0, IM_BASE} + (33'(IM_WORDS) * 33'd4);

   logic [31:0] target;
   logic        mis;
   logic        low;
   logic        high;

   pc_ctrl_npc_calc u_npc (
      .pc_f     (pc_f),
      .pc_d     (pc_d),
      .valid_d  (valid_d),
      .npc_op   (npc_op_d),
      .br_cond  (br_cond_d),
      .imm16    (imm16_d),
      .imm26    (imm26_d),
      .rs       (rs_d),
      .target   (target),
      .redirect (redirect_d)
   );

   assign link_d = pc_d + 32'd8;

   assign mis  = (pc_f[1:0] != 2'b00);
   assign low  = (pc_f < IM_BASE);
   assign high = ({1'b0, pc_f} >= IM_END);

   // Fetch address error; the PC keeps advancing regardless.
   always_comb begin
      adel_f = mis | low | high;
   end

   // PC pipeline and perf counter; reset beats stall.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pc_f      <= RESET_PC;
         pc_d      <= 32'd0;
         valid_d   <= 1'b0;
         taken_cnt <= 32'd0;
      end else if (!stall_i) begin
         pc_f      <= target;
         pc_d      <= pc_f;
         valid_d   <= 1'b1;
         taken_cnt <= taken_cnt + {31'd0, redirect_d};
      end
   end

endmodule

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl: stimulus steps push
// expected state, popped after each clock edge.
module tb_pc_ctrl;
   import pc_ctrl_pkg::*;

   typedef struct {
      logic        stall;
      logic [2:0]  op;
      logic        cond;
      logic [15:0] i16;
      logic [25:0] i26;
      logic [31:0] rs;
   } st_t;

   typedef struct {
      logic        redir;
      logic [31:0] pcf;
      logic [31:0] pcd;
      logic        vd;
      logic [31:0] cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        stall_i;
   logic [2:0]  npc_op_d;
   logic        br_cond_d;
   logic [15:0] imm16_d;
   logic [25:0] imm26_d;
   logic [31:0] rs_d;
   logic [31:0] pc_f;
   logic [31:0] pc_d;
   logic        valid_d;
   logic [31:0] link_d;
   logic        redirect_d;
   logic        adel_f;
   logic [31:0] taken_cnt;

   int   n_pass = 0;
   int   n_tot  = 0;
   exp_t sb[$];

   pc_ctrl dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .stall_i    (stall_i),
      .npc_op_d   (npc_op_d),
      .br_cond_d  (br_cond_d),
      .imm16_d    (imm16_d),
      .imm26_d    (imm26_d),
      .rs_d       (rs_d),
      .pc_f       (pc_f),
      .pc_d       (pc_d),
      .valid_d    (valid_d),
      .link_d     (link_d),
      .redirect_d (redirect_d),
      .adel_f     (adel_f),
      .taken_cnt  (taken_cnt)
   );

   always #5 clk = ~clk;

   function automatic st_t S(input logic st, input logic [2:0] op,
                             input logic c, input logic [15:0] a,
                             input logic [25:0] b, input logic [31:0] r);
      st_t s;
      s.stall = st; s.op = op; s.cond = c;
      s.i16 = a; s.i26 = b; s.rs = r;
      return s;
   endfunction

   function automatic exp_t E(input logic rd, input logic [31:0] f,
                              input logic [31:0] d, input logic v,
                              input logic [31:0] c);
      exp_t e;
      e.redir = rd; e.pcf = f; e.pcd = d; e.vd = v; e.cnt = c;
      return e;
   endfunction

   // Legal range is [0x3000, 0x7000), word aligned.
   function automatic logic bad(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a < 32'h3000) || (a >= 32'h7000);
   endfunction

   task automatic apply(input st_t s, input exp_t e);
      stall_i   = s.stall;
      npc_op_d  = s.op;
      br_cond_d = s.cond;
      imm16_d   = s.i16;
      imm26_d   = s.i26;
      rs_d      = s.rs;
      sb.push_back(e);
   endtask

   task automatic test_reset();
      exp_t e;
      reset_n = 1'b0;
      apply(S(0, NPC_J, 1, 16'hFFFF, 26'h3FF_FFFF, 32'hDEAD_BEEF),
            E(0, 32'h3000, 32'h0, 0, 32'h0));
      repeat (2) @(posedge clk);
      #1;
      e = sb.pop_front();
      n_tot++;
      if ({pc_f, pc_d, valid_d, taken_cnt} !== {e.pcf, e.pcd, e.vd, e.cnt})
         $display("FAIL reset_state got %h %h %b %h want %h %h %b %h",
                  pc_f, pc_d, valid_d, taken_cnt, e.pcf, e.pcd, e.vd, e.cnt);
      else n_pass++;
      n_tot++;
      if (redirect_d !== 1'b0)
         $display("FAIL reset_redirect got %b want 0", redirect_d);
      else n_pass++;
      n_tot++;
      if (link_d !== 32'h8 || adel_f !== 1'b0)
         $display("FAIL reset_link_adel got %h %b want 8 0", link_d, adel_f);
      else n_pass++;
   endtask

   task automatic run_list(input string nm, input st_t s[$], input exp_t x[$]);
      exp_t e;
      for (int i = 0; i < s.size(); i++) begin
         apply(s[i], x[i]);
         #1;
         n_tot++;
         if (redirect_d !== x[i].redir)
            $display("FAIL %s[%0d] redirect got %b want %b",
                     nm, i, redirect_d, x[i].redir);
         else n_pass++;
         @(posedge clk);
         #1;
         e = sb.pop_front();
         n_tot++;
         if ({pc_f, pc_d, valid_d, taken_cnt} !== {e.pcf, e.pcd, e.vd, e.cnt})
            $display("FAIL %s[%0d] state got %h %h %b %h want %h %h %b %h",
                     nm, i, pc_f, pc_d, valid_d, taken_cnt,
                     e.pcf, e.pcd, e.vd, e.cnt);
         else n_pass++;
         n_tot++;
         if (link_d !== e.pcd + 32'd8)
            $display("FAIL %s[%0d] link got %h want %h",
                     nm, i, link_d, e.pcd + 32'd8);
         else n_pass++;
         n_tot++;
         if (adel_f !== bad(e.pcf))
            $display("FAIL %s[%0d] adel got %b want %b",
                     nm, i, adel_f, bad(e.pcf));
         else n_pass++;
      end
   endtask

   task automatic test_seq();
      st_t s[$]; exp_t x[$];
      reset_n = 1'b1;
      s.push_back(S(0, NPC_J, 1, 0, 26'h3FF_FFFF, 32'hFFFF_FFFF));
      x.push_back(E(0, 32'h3004, 32'h3000, 1, 0));
      s.push_back(S(0, NPC_SEQ, 0, 0, 0, 0));
      x.push_back(E(0, 32'h3008, 32'h3004, 1, 0));
      s.push_back(S(0, NPC_SEQ, 0, 0, 0, 0));
      x.push_back(E(0, 32'h300C, 32'h3008, 1, 0));
      s.push_back(S(0, NPC_SEQ, 1, 0, 0, 0));
      x.push_back(E(0, 32'h3010, 32'h300C, 1, 0));
      s.push_back(S(0, NPC_SEQ, 0, 0, 0, 0));
      x.push_back(E(0, 32'h3014, 32'h3010, 1, 0));
      run_list("seq", s, x);
   endtask

   task automatic test_branch();
      st_t s[$]; exp_t x[$];
      s.push_back(S(0, NPC_BR, 1, 16'hFFFE, 0, 0));
      x.push_back(E(1, 32'h300C, 32'h3014, 1, 1));
      s.push_back(S(0, NPC_SEQ, 0, 0, 0, 0));
      x.push_back(E(0, 32'h3010, 32'h300C, 1, 1));
      s.push_back(S(0, NPC_BR, 0, 16'hFFFE, 0, 0));
      x.push_back(E(0, 32'h3014, 32'h3010, 1, 1));
      s.push_back(S(0, 3'd5, 1, 16'h0040, 26'h3FF_FFFF, 32'h5000));
      x.push_back(E(0, 32'h3018, 32'h3014, 1, 1));
      run_list("branch", s, x);
   endtask

   task automatic test_jr_stall();
      st_t s[$]; exp_t x[$];
      s.push_back(S(1, NPC_JR, 0, 0, 0, 32'h3002));
      x.push_back(E(1, 32'h3018, 32'h3014, 1, 1));
      s.push_back(S(1, NPC_JR, 0, 0, 0, 32'h3002));
      x.push_back(E(1, 32'h3018, 32'h3014, 1, 1));
      s.push_back(S(0, NPC_JR, 0, 0, 0, 32'h3002));
      x.push_back(E(1, 32'h3002, 32'h3018, 1, 2));
      s.push_back(S(0, NPC_SEQ, 0, 0, 0, 0));
      x.push_back(E(0, 32'h3006, 32'h3002, 1, 2));
      run_list("jr_stall", s, x);
   endtask

   task automatic test_range();
      st_t s[$]; exp_t x[$];
      s.push_back(S(0, NPC_JR, 0, 0, 0, 32'h6FFC));
      x.push_back(E(1, 32'h6FFC, 32'h3006, 1, 3));
      s.push_back(S(0, NPC_SEQ, 0, 0, 0, 0));
      x.push_back(E(0, 32'h7000, 32'h6FFC, 1, 3));
      s.push_back(S(0, NPC_JR, 0, 0, 0, 32'h2FFC));
      x.push_back(E(1, 32'h2FFC, 32'h7000, 1, 4));
      s.push_back(S(0, NPC_JR, 0, 0, 0, 32'h3000));
      x.push_back(E(1, 32'h3000, 32'h2FFC, 1, 5));
      run_list("range", s, x);
   endtask

   task automatic test_jump();
      st_t s[$]; exp_t x[$];
      s.push_back(S(0, NPC_SEQ, 0, 0, 0, 0));
      x.push_back(E(0, 32'h3004, 32'h3000, 1, 5));
      s.push_back(S(0, NPC_J, 0, 0, 26'h0000C40, 0));
      x.push_back(E(1, 32'h3100, 32'h3004, 1, 6));
      s.push_back(S(0, NPC_JR, 0, 0, 0, 32'hF000_0000));
      x.push_back(E(1, 32'hF000_0000, 32'h3100, 1, 7));
      s.push_back(S(0, NPC_SEQ, 0, 0, 0, 0));
      x.push_back(E(0, 32'hF000_0004, 32'hF000_0000, 1, 7));
      s.push_back(S(0, NPC_J, 0, 0, 26'h0000C40, 0));
      x.push_back(E(1, 32'hF000_3100, 32'hF000_0004, 1, 8));
      s.push_back(S(0, NPC_JR, 0, 0, 0, 32'hFFFF_FFFC));
      x.push_back(E(1, 32'hFFFF_FFFC, 32'hF000_3100, 1, 9));
      s.push_back(S(0, NPC_SEQ, 0, 0, 0, 0));
      x.push_back(E(0, 32'h0000_0000, 32'hFFFF_FFFC, 1, 9));
      s.push_back(S(0, NPC_BR, 1, 16'h0001, 0, 0));
      x.push_back(E(1, 32'h0000_0004, 32'h0000_0000, 1, 10));
      run_list("jump", s, x);
   endtask

   task automatic test_wrap();
      st_t s[$]; exp_t x[$];
      force dut.taken_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.taken_cnt;
      #1;
      n_tot++;
      if (taken_cnt !== 32'hFFFF_FFFF)
         $display("FAIL wrap_preload got %h want ffffffff", taken_cnt);
      else n_pass++;
      s.push_back(S(0, NPC_JR, 0, 0, 0, 32'h3000));
      x.push_back(E(1, 32'h3000, 32'h0000_0004, 1, 0));
      s.push_back(S(0, NPC_SEQ, 0, 0, 0, 0));
      x.push_back(E(0, 32'h3004, 32'h3000, 1, 0));
      run_list("wrap", s, x);
   endtask

   task automatic test_reset_mid();
      exp_t e;
      apply(S(1, NPC_BR, 1, 16'hFFFE, 0, 0),
            E(1, 32'h3000, 32'h0, 0, 32'h0));
      reset_n = 1'b0;
      #1;
      n_tot++;
      if (redirect_d !== 1'b1)
         $display("FAIL rst_mid_redirect got %b want 1", redirect_d);
      else n_pass++;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      stall_i = 1'b0;
      #1;
      e = sb.pop_front();
      n_tot++;
      if ({pc_f, pc_d, valid_d, taken_cnt} !== {e.pcf, e.pcd, e.vd, e.cnt})
         $display("FAIL rst_mid_state got %h %h %b %h want %h %h %b %h",
                  pc_f, pc_d, valid_d, taken_cnt, e.pcf, e.pcd, e.vd, e.cnt);
      else n_pass++;
      n_tot++;
      if (redirect_d !== 1'b0)
         $display("FAIL rst_mid_idle got %b want 0", redirect_d);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      st_t s[$]; exp_t x[$];
      s.push_back(S(0, NPC_SEQ, 0, 0, 0, 0));
      x.push_back(E(0, 32'h3004, 32'h3000, 1, 0));
      s.push_back(S(0, NPC_BR, 1, 16'h0010, 0, 0));
      x.push_back(E(1, 32'h3044, 32'h3004, 1, 1));
      s.push_back(S(0, NPC_BR, 1, 16'h0010, 0, 0));
      x.push_back(E(1, 32'h3048, 32'h3044, 1, 2));
      run_list("b2b", s, x);
   endtask

   initial begin
      reset_n   = 1'b0;
      stall_i   = 1'b0;
      npc_op_d  = NPC_SEQ;
      br_cond_d = 1'b0;
      imm16_d   = '0;
      imm26_d   = '0;
      rs_d      = '0;
      test_reset();
      test_seq();
      test_branch();
      test_jr_stall();
      test_range();
      test_jump();
      test_wrap();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
